// File: rtl/prng_if.sv
// Output bundle of the pseudo-random generator: the current LFSR state.
interface prng_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] out;

    modport master (output out);
    modport slave  (input  out);
endinterface

// File: rtl/prng.sv
// Free-running maximal-length Galois LFSR (right shift); out is the state register.
module prng #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400
) (
    input  logic     clk,
    input  logic     rst,
    prng_if.master   bus
);
    // An all-zero state never leaves zero, so it is replaced by a nonzero restart value.
    localparam logic [WIDTH-1:0] RECOVER = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] s = SEED;
    logic [WIDTH-1:0] s_next;

    always_comb begin
        s_next = (s >> 1) ^ (s[0] ? TAPS : '0);
        if (s == '0) begin
            s_next = RECOVER;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s <= SEED;
        end else begin
            s <= s_next;
        end
    end

    assign bus.out = s;
endmodule

// File: tb/tb_prng.sv
// Bench for prng: sequence-table reference model, per-cycle compare, directed and random resets.
module tb_prng;
    localparam logic [15:0] SEED   = 16'hACE1;
    localparam logic [15:0] TAPS   = 16'hB400;
    localparam int          PERIOD = 65535;

    logic clk = 1'b0;
    logic rst = 1'b0;

    prng_if #(.WIDTH(16)) bus ();

    prng #(.WIDTH(16), .SEED(SEED), .TAPS(TAPS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: the whole period laid out as a table, tracked by position.
    logic [15:0] seq [PERIOD];
    int          idx = 0;
    logic        zero_pending = 1'b0;

    bit          seen [65536];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] galois_step(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? TAPS : 16'h0000);
    endfunction

    // Compare process: advance the model on each rising edge, check out on each falling edge.
    initial begin
        seq[0] = SEED;
        for (int i = 1; i < PERIOD; i++) begin
            seq[i] = galois_step(seq[i-1]);
        end
        chk("model_step1", seq[1], 16'hE270);
        chk("model_step2", seq[2], 16'h7138);
        chk("model_step3", seq[3], 16'h389C);
        chk("model_step4", seq[4], 16'h1C4E);
        chk("model_step5", seq[5], 16'h0E27);
        chk("model_wrap", galois_step(seq[PERIOD-1]), SEED);
        #2;
        chk("powerup", bus.out, SEED);
        forever begin
            @(posedge clk);
            if (rst) begin
                idx = 0;
            end else if (zero_pending) begin
                idx = 0;
                zero_pending = 1'b0;
            end else begin
                idx = (idx + 1) % PERIOD;
            end
            @(negedge clk);
            if (zero_pending) begin
                chk("cycle_zero", bus.out, 16'h0000);
            end else begin
                chk("cycle", bus.out, seq[idx]);
            end
        end
    end

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int early;
        int distinct;
        int zeros;

        // Power-up sequence without any reset.
        edges(1); chk("pu_e1", bus.out, 16'hE270);
        edges(1); chk("pu_e2", bus.out, 16'h7138);
        edges(1); chk("pu_e3", bus.out, 16'h389C);
        edges(1); chk("pu_e4", bus.out, 16'h1C4E);
        edges(1); chk("pu_e5", bus.out, 16'h0E27);

        // Full period from SEED: wrap at exactly 65535, all values distinct and nonzero.
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        chk("period_start", bus.out, SEED);
        early = 0;
        distinct = 0;
        zeros = 0;
        seen[bus.out] = 1'b1;
        distinct++;
        for (int k = 1; k <= PERIOD; k++) begin
            edges(1);
            if (k < PERIOD) begin
                if (bus.out === SEED) early++;
                if (bus.out === 16'h0000 || $isunknown(bus.out)) zeros++;
                if (!$isunknown(bus.out) && !seen[bus.out]) begin
                    seen[bus.out] = 1'b1;
                    distinct++;
                end
            end
        end
        chk("wrap_at_65535", bus.out, SEED);
        chk_int("no_early_wrap", early, 0);
        chk_int("distinct_values", distinct, PERIOD);
        chk_int("zero_or_x_values", zeros, 0);
        edges(1);
        chk("after_wrap", bus.out, 16'hE270);

        // Single-edge reset mid-sequence.
        edges(1000);
        rst = 1'b1;
        edges(1);
        rst = 1'b0;
        chk("rst1_seed", bus.out, SEED);
        edges(1);
        chk("rst1_next", bus.out, 16'hE270);

        // Reset held for several edges.
        edges(37);
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            edges(1);
            chk("rst_hold", bus.out, SEED);
        end
        rst = 1'b0;
        edges(1);
        chk("rst_release", bus.out, 16'hE270);

        // Lock-up guard: corrupt the state to zero.
        edges(3);
        zero_pending = 1'b1;
        dut.s <= 16'h0000;
        #1;
        chk("forced_zero", bus.out, 16'h0000);
        edges(1);
        chk("lockup_seed", bus.out, SEED);
        edges(1);
        chk("lockup_next", bus.out, 16'hE270);

        // Random run lengths separated by random-length resets.
        for (int r = 0; r < 20; r++) begin
            edges($urandom_range(1, 150));
            rst = 1'b1;
            edges($urandom_range(1, 3));
            rst = 1'b0;
            chk("rand_rst", bus.out, SEED);
        end
        edges(10);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1500000;
        errors++;
        $display("FAIL watchdog got timeout expected completion at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
